// File: rtl/half_vector_gather_pkg.sv
// ---------------------------------------------------------------------------
// half_vector_gather_pkg
// Shared half-precision definitions for the min-reduction datapath.
//   half_t        : raw IEEE-754 binary16 bit pattern
//   HALF_POS_INF  : +infinity (neutral element for min)
//   HALF_NEG_INF  : -infinity
//   HALF_QNAN     : canonical quiet NaN
// ---------------------------------------------------------------------------
package half_vector_gather_pkg;

  typedef logic [15:0] half_t;

  localparam half_t HALF_POS_INF = 16'h7C00;
  localparam half_t HALF_NEG_INF = 16'hFC00;
  localparam half_t HALF_QNAN    = 16'h7E00;

endpackage : half_vector_gather_pkg

// File: rtl/half_vector_gather.sv
// ---------------------------------------------------------------------------
// half_vector_gather
// Serial-to-parallel collector: accepts one half-precision element per cycle
// and presents WIDTH elements as one vector. A vector closes when the last
// slot is written or when the accepted element carries in_last; unfilled
// slots are padded with PAD.
//
// Ports:
//   clk        : clock, all state on rising edge
//   rstn       : asynchronous active-low reset
//   in_valid   : element a is presented
//   in_ready   : element can be accepted this cycle
//   a          : half-precision element (passed bit-exact)
//   in_last    : with accepted element, closes the current vector early
//   out_valid  : vector_c / out_count valid
//   out_ready  : consumer takes the vector this cycle
//   vector_c   : assembled vector, slot 0 holds the first element
//   out_count  : number of real elements in vector_c (1..WIDTH)
// ---------------------------------------------------------------------------
module half_vector_gather
  import half_vector_gather_pkg::*;
#(
  parameter int    WIDTH = 16,
  parameter half_t PAD   = HALF_POS_INF
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  half_t                      a,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output half_t                      vector_c [WIDTH],
  output logic [$clog2(WIDTH+1)-1:0] out_count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);

  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  // Assembly side
  logic [IW-1:0] idx_r;
  half_t         asm_r [WIDTH];

  // Output register
  half_t         vec_r [WIDTH];
  logic [CW-1:0] count_r;
  logic          valid_r;

  logic          accept_s;
  logic          done_s;
  half_t         vec_next_s [WIDTH];

  // The output register frees up in the same cycle it is consumed, so a
  // completing element may overwrite it while it is being taken.
  assign in_ready = !valid_r || out_ready;
  assign accept_s = in_valid && in_ready;
  assign done_s   = accept_s && ((idx_r == IDX_LAST) || in_last);

  // Next output vector: buffered slots below idx, the incoming element at
  // idx, PAD above it.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      vec_next_s[i] = PAD;
      if (IW'(i) < idx_r) begin
        vec_next_s[i] = asm_r[i];
      end else if (IW'(i) == idx_r) begin
        vec_next_s[i] = a;
      end else begin
        vec_next_s[i] = PAD;
      end
    end
  end

  // Fill index and assembly buffer; both restart on vector completion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_r <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        asm_r[i] <= PAD;
      end
    end else if (done_s) begin
      idx_r <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        asm_r[i] <= PAD;
      end
    end else if (accept_s) begin
      asm_r[idx_r] <= a;
      idx_r        <= idx_r + IW'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  // Output register: loads on completion, clears valid on a bare transfer,
  // otherwise holds so the consumer sees a stable vector.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_r <= 1'b0;
      count_r <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        vec_r[i] <= PAD;
      end
    end else if (done_s) begin
      valid_r <= 1'b1;
      count_r <= CW'(idx_r) + CW'(1);
      for (int i = 0; i < WIDTH; i++) begin
        vec_r[i] <= vec_next_s[i];
      end
    end else if (valid_r && out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign out_valid = valid_r;
  assign out_count = count_r;
  assign vector_c  = vec_r;

endmodule : half_vector_gather

// File: tb/tb_half_vector_gather.sv
// ---------------------------------------------------------------------------
// tb_half_vector_gather
// Directed scoreboard bench for half_vector_gather with WIDTH = 4.
// Stimulus pushes hand-computed expected vectors; a monitor pops and compares
// every output transfer.
// ---------------------------------------------------------------------------
module tb_half_vector_gather;
  import half_vector_gather_pkg::*;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  half_t         a = 16'h0000;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  half_t         vector_c [W];
  logic [CW-1:0] out_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] v [W];
    int          cnt;
  } exp_t;

  exp_t sb [$];

  half_vector_gather #(.WIDTH(W), .PAD(HALF_POS_INF)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .vector_c  (vector_c),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_vec(input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3, input int cnt);
    exp_t e;
    e.v[0] = e0; e.v[1] = e1; e.v[2] = e2; e.v[3] = e3;
    e.cnt  = cnt;
    sb.push_back(e);
  endtask

  // Drive one element and wait (bounded) until it is accepted.
  task automatic send(input logic [15:0] d, input logic l, output int stalls);
    in_valid = 1'b1;
    a        = d;
    in_last  = l;
    stalls   = 0;
    @(negedge clk);
    while (!in_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Monitor: compare every output transfer against the scoreboard head.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_vector", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        for (int i = 0; i < W; i++) begin
          chk($sformatf("vector_c[%0d]", i), {16'h0000, vector_c[i]}, {16'h0000, e.v[i]});
        end
        chk("out_count", 32'(out_count), 32'(e.cnt));
      end
    end
  end

  int st;
  logic [15:0] held [W];

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_vector_c0", {16'h0000, vector_c[0]}, 32'h7C00);
    chk("rst_vector_c3", {16'h0000, vector_c[3]}, 32'h7C00);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // 1: full vector, one-cycle latency, no stalls
    expect_vec(16'h3C00, 16'h4000, 16'h4200, 16'h4400, 4);
    send(16'h3C00, 1'b0, st); chk("t1_stall0", 32'(st), 32'd0);
    chk("t1_no_early_valid", 32'(out_valid), 32'd0);
    send(16'h4000, 1'b0, st); chk("t1_stall1", 32'(st), 32'd0);
    send(16'h4200, 1'b0, st); chk("t1_stall2", 32'(st), 32'd0);
    send(16'h4400, 1'b0, st); chk("t1_stall3", 32'(st), 32'd0);
    chk("t1_latency_valid", 32'(out_valid), 32'd1);

    // 2: short vector via in_last, next element restarts at slot 0
    expect_vec(16'h4500, 16'h4600, 16'h7C00, 16'h7C00, 2);
    send(16'h4500, 1'b0, st);
    send(16'h4600, 1'b1, st);
    chk("t2_valid", 32'(out_valid), 32'd1);

    // 3: eight back-to-back elements, two vectors, no input bubble
    expect_vec(16'h3C00, 16'h4000, 16'h4200, 16'h4400, 4);
    expect_vec(16'h4500, 16'h4600, 16'h4700, 16'h4800, 4);
    send(16'h3C00, 1'b0, st); chk("t3_stall0", 32'(st), 32'd0);
    send(16'h4000, 1'b0, st);
    send(16'h4200, 1'b0, st);
    send(16'h4400, 1'b0, st);
    send(16'h4500, 1'b0, st); chk("t3_stall4", 32'(st), 32'd0);
    send(16'h4600, 1'b0, st);
    send(16'h4700, 1'b0, st);
    send(16'h4800, 1'b0, st); chk("t3_stall7", 32'(st), 32'd0);
    chk("t3_valid", 32'(out_valid), 32'd1);

    // 4: backpressure holds the vector and stalls input
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    expect_vec(16'h4900, 16'h4A00, 16'h4B00, 16'h4C00, 4);
    send(16'h4900, 1'b0, st);
    send(16'h4A00, 1'b0, st);
    send(16'h4B00, 1'b0, st);
    send(16'h4C00, 1'b0, st);
    held[0] = 16'h4900; held[1] = 16'h4A00; held[2] = 16'h4B00; held[3] = 16'h4C00;
    in_valid = 1'b1;
    a        = 16'h5000;
    in_last  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_in_ready_low", 32'(in_ready), 32'd0);
      chk("t4_hold_count", 32'(out_count), 32'd4);
      for (int i = 0; i < W; i++) begin
        chk("t4_hold_vec", {16'h0000, vector_c[i]}, {16'h0000, held[i]});
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_in_ready_high", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expect_vec(16'h5000, 16'h5100, 16'h7C00, 16'h7C00, 2);
    send(16'h5100, 1'b1, st);

    // 5: reset mid-vector discards partial data
    @(posedge clk);
    #1;
    send(16'h5200, 1'b0, st);
    send(16'h5300, 1'b0, st);
    rstn = 1'b0;
    @(negedge clk);
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_count", 32'(out_count), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    expect_vec(16'h3800, 16'h3400, 16'h3000, 16'h2C00, 4);
    send(16'h3800, 1'b0, st);
    send(16'h3400, 1'b0, st);
    send(16'h3000, 1'b0, st);
    send(16'h2C00, 1'b0, st);

    // 6: NaN payload and negative zero pass bit-exact
    expect_vec(16'h7E01, 16'h8000, 16'h7C00, 16'h7C00, 2);
    send(16'h7E01, 1'b0, st);
    send(16'h8000, 1'b1, st);

    // Drain with a bounded wait
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_half_vector_gather
